block_sync_rx: RTL



---
 rtl/block_sync_rx.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/block_sync_rx.sv
// ---------------------------------------------------------------------------
// block_sync_rx
//
// 64b/66b block synchronisation state machine. Watches the 2-bit sync header
// of every block delivered by the rx gearbox, asks the gearbox to slip by one
// bit position until headers line up, and reports block lock to the
// descrambler/decoder.
//
// Lock is declared after SH_CNT_MAX consecutive valid headers. Once locked,
// lock is dropped when SH_INVALID_MAX invalid headers are seen inside one
// SH_CNT_MAX-block window. After every slip the next SLIP_WAIT valid blocks
// are ignored while the gearbox realigns.
//
// Ports:
//   clk         in   1       clock
//   reset       in   1       synchronous active-high reset
//   signal_v_i  in   1       PMA signal_ok; low forces re-initialisation
//   valid_i     in   1       gearbox block valid; head_i used only when high
//   head_i      in   HEAD_W  sync header of the current 66-bit block
//   slip_v_o    out  1       one-cycle slip request to the gearbox
//   lock_v_o    out  1       block lock status
// ---------------------------------------------------------------------------
module block_sync_rx #(
   parameter int HEAD_W         = 2,
   parameter int SH_CNT_MAX     = 64,
   parameter int SH_INVALID_MAX = 16,
   parameter int SLIP_WAIT      = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              signal_v_i,
   input  logic              valid_i,
   input  logic [HEAD_W-1:0] head_i,
   output logic              slip_v_o,
   output logic              lock_v_o
);

   localparam int CNT_W  = $clog2(SH_CNT_MAX + 1);
   localparam int INV_W  = $clog2(SH_INVALID_MAX + 1);
   localparam int WAIT_W = (SLIP_WAIT > 0) ? $clog2(SLIP_WAIT + 1) : 1;

   typedef enum logic [1:0] {
      INIT,
      TEST,
      SLIP,
      WAIT
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  sh_cnt;
   logic [INV_W-1:0]  sh_inv_cnt;
   logic [WAIT_W-1:0] wait_cnt;

   logic              sh_valid;
   logic [CNT_W-1:0]  cnt_next;
   logic [INV_W-1:0]  inv_next;
   logic [WAIT_W-1:0] wait_next;

   // A valid sync header has exactly one bit set (01 or 10).
   assign sh_valid  = head_i[1] ^ head_i[0];
   assign cnt_next  = sh_cnt + CNT_W'(1);
   assign inv_next  = sh_inv_cnt + INV_W'(!sh_valid);
   assign wait_next = wait_cnt + WAIT_W'(1);

   // Single registered FSM. Losing signal_ok outranks everything except
   // reset, so a slip that would otherwise be raised on that edge is dropped.
   // slip_v_o defaults low every cycle, which keeps it a one-cycle pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= INIT;
         sh_cnt     <= '0;
         sh_inv_cnt <= '0;
         wait_cnt   <= '0;
         lock_v_o   <= 1'b0;
         slip_v_o   <= 1'b0;
      end else if (!signal_v_i) begin
         state      <= INIT;
         sh_cnt     <= '0;
         sh_inv_cnt <= '0;
         wait_cnt   <= '0;
         lock_v_o   <= 1'b0;
         slip_v_o   <= 1'b0;
      end else begin
         slip_v_o <= 1'b0;
         case (state)
            INIT: begin
               sh_cnt     <= '0;
               sh_inv_cnt <= '0;
               wait_cnt   <= '0;
               lock_v_o   <= 1'b0;
               state      <= TEST;
            end

            TEST: begin
               if (valid_i) begin
                  if (sh_valid) begin
                     if (cnt_next == CNT_W'(SH_CNT_MAX)) begin
                        // End of a window: a clean window grants lock,
                        // a window with errors just starts a new count.
                        if (sh_inv_cnt == '0) begin
                           lock_v_o <= 1'b1;
                        end
                        sh_cnt     <= '0;
                        sh_inv_cnt <= '0;
                     end else begin
                        sh_cnt <= cnt_next;
                     end
                  end else if (!lock_v_o || inv_next == INV_W'(SH_INVALID_MAX)) begin
                     // Unlocked: any bad header means misalignment.
                     // Locked: too many bad headers in this window.
                     lock_v_o   <= 1'b0;
                     slip_v_o   <= 1'b1;
                     sh_cnt     <= '0;
                     sh_inv_cnt <= '0;
                     state      <= SLIP;
                  end else if (cnt_next == CNT_W'(SH_CNT_MAX)) begin
                     sh_cnt     <= '0;
                     sh_inv_cnt <= '0;
                  end else begin
                     sh_cnt     <= cnt_next;
                     sh_inv_cnt <= inv_next;
                  end
               end
            end

            SLIP: begin
               lock_v_o   <= 1'b0;
               sh_cnt     <= '0;
               sh_inv_cnt <= '0;
               wait_cnt   <= '0;
               state      <= (SLIP_WAIT == 0) ? TEST : WAIT;
            end

            WAIT: begin
               // Headers are meaningless until the gearbox has settled.
               if (valid_i) begin
                  if (wait_next == WAIT_W'(SLIP_WAIT)) begin
                     wait_cnt <= '0;
                     state    <= TEST;
                  end else begin
                     wait_cnt <= wait_next;
                  end
               end
            end

            default: begin
               state <= INIT;
            end
         endcase
      end
   end

   a_slip_lock_exclusive: assert property (@(posedge clk) disable iff (reset)
      !(slip_v_o && lock_v_o));
   a_sh_cnt_range: assert property (@(posedge clk) disable iff (reset)
      sh_cnt <= CNT_W'(SH_CNT_MAX));
   a_sh_inv_cnt_range: assert property (@(posedge clk) disable iff (reset)
      sh_inv_cnt <= INV_W'(SH_INVALID_MAX));

endmodule
